cpld_xc2c64a_top: RTL and testbench

// - Top level of the XC2C64A CPLD on the 4x4x4 LED cube board.
// - Generates a stretched active-low reset (resetn_cube) for the cube controller.
// - Synchronises and debounces two active-low push buttons (mode, light).
// - Forwards the clean button levels to the cube controller.
// - Runs from one 24 MHz system clock (41.6 ns period).

---
 rtl/cpld_xc2c64a_top.sv | 83 ++++++++
 tb/tb_cpld_xc2c64a_top.sv | 139 +++++++++++++
 2 files changed

// File: rtl/cpld_xc2c64a_top.sv
// rtl/cpld_xc2c64a_top.sv - XC2C64A LED cube top: reset stretcher and button sync/debounce
module cpld_xc2c64a_top #(
    parameter int CLK_HZ            = 24_000_000,
    parameter int SYNC_STAGES       = 2,
    parameter int DEBOUNCE_CYCLES   = 120_000,
    parameter int RESET_HOLD_CYCLES = 240_000
) (
    input  logic clk_system,
    input  logic reset_system,
    input  logic mode_selector_in,
    input  logic light_selector_in,
    output logic resetn_cube,
    output logic mode_selector_out,
    output logic light_selector_out
);

    localparam int DW = $clog2(DEBOUNCE_CYCLES) + 1;
    localparam int HW = $clog2(RESET_HOLD_CYCLES) + 1;
    localparam logic [DW-1:0] DB_LAST   = DW'(DEBOUNCE_CYCLES - 1);
    localparam logic [DW-1:0] DB_ONE    = DW'(1);
    localparam logic [HW-1:0] HOLD_LAST = HW'(RESET_HOLD_CYCLES - 1);
    localparam logic [HW-1:0] HOLD_ONE  = HW'(1);

    logic [HW-1:0] hold_cnt;
    logic [1:0]    btn_in;
    logic [1:0]    sel_q;

    assign btn_in             = {light_selector_in, mode_selector_in};
    assign mode_selector_out  = sel_q[0];
    assign light_selector_out = sel_q[1];

    // Counter stops advancing once resetn_cube is released, so it saturates.
    always_ff @(posedge clk_system) begin
        if (reset_system) begin
            hold_cnt    <= '0;
            resetn_cube <= 1'b0;
        end else if (!resetn_cube) begin
            if (hold_cnt == HOLD_LAST) begin
                resetn_cube <= 1'b1;
            end else begin
                hold_cnt <= hold_cnt + HOLD_ONE;
            end
        end
    end

    for (genvar b = 0; b < 2; b++) begin : g_btn
        logic [SYNC_STAGES-1:0] sync_q;
        logic [DW-1:0]          db_cnt;
        logic                   stable;

        always_ff @(posedge clk_system) begin
            if (reset_system) begin
                sync_q <= '1;
            end else begin
                sync_q <= {sync_q[SYNC_STAGES-2:0], btn_in[b]};
            end
        end

        // A new level is accepted only after DEBOUNCE_CYCLES consecutive differing samples.
        always_ff @(posedge clk_system) begin
            if (reset_system) begin
                db_cnt <= '0;
                stable <= 1'b1;
            end else if (sync_q[SYNC_STAGES-1] == stable) begin
                db_cnt <= '0;
            end else if (db_cnt == DB_LAST) begin
                db_cnt <= '0;
                stable <= sync_q[SYNC_STAGES-1];
            end else begin
                db_cnt <= db_cnt + DB_ONE;
            end
        end

        always_ff @(posedge clk_system) begin
            if (reset_system || !resetn_cube) begin
                sel_q[b] <= 1'b1;
            end else begin
                sel_q[b] <= stable;
            end
        end
    end

endmodule

// File: tb/tb_cpld_xc2c64a_top.sv
// tb/tb_cpld_xc2c64a_top.sv - directed self-checking bench for cpld_xc2c64a_top
module tb_cpld_xc2c64a_top;

    logic clk_system = 1'b0;
    logic reset_system;
    logic mode_selector_in;
    logic light_selector_in;
    logic resetn_cube;
    logic mode_selector_out;
    logic light_selector_out;

    int n_checks = 0;
    int n_fails  = 0;
    logic glitch_watch = 1'b0;
    logic glitch_bad   = 1'b0;

    cpld_xc2c64a_top #(
        .SYNC_STAGES       (2),
        .DEBOUNCE_CYCLES   (16),
        .RESET_HOLD_CYCLES (32)
    ) dut (
        .clk_system         (clk_system),
        .reset_system       (reset_system),
        .mode_selector_in   (mode_selector_in),
        .light_selector_in  (light_selector_in),
        .resetn_cube        (resetn_cube),
        .mode_selector_out  (mode_selector_out),
        .light_selector_out (light_selector_out)
    );

    always #21 clk_system = ~clk_system;

    always @(negedge clk_system) begin
        if (glitch_watch && (mode_selector_out !== 1'b1 || light_selector_out !== 1'b1))
            glitch_bad <= 1'b1;
    end

    task automatic step();
        @(posedge clk_system);
        #1;
    endtask

    task automatic check(input string tag, input logic observed, input logic expected);
        n_checks++;
        assert (observed === expected) else begin
            n_fails++;
            $error("FAIL %s observed=%b expected=%b at %0t", tag, observed, expected, $time);
        end
    endtask

    initial begin
        reset_system      = 1'b1;
        mode_selector_in  = 1'b1;
        light_selector_in = 1'b1;
        repeat (3) step();
        check("reset_resetn", resetn_cube, 1'b0);
        check("reset_mode", mode_selector_out, 1'b1);
        check("reset_light", light_selector_out, 1'b1);

        reset_system = 1'b0;
        for (int i = 1; i <= 40; i++) begin
            step();
            check("stretch_resetn", resetn_cube, (i >= 32) ? 1'b1 : 1'b0);
            check("stretch_mode", mode_selector_out, 1'b1);
            check("stretch_light", light_selector_out, 1'b1);
        end

        mode_selector_in = 1'b0;
        for (int i = 1; i <= 100; i++) begin
            step();
            check("press_mode", mode_selector_out, (i >= 19) ? 1'b0 : 1'b1);
            check("press_light", light_selector_out, 1'b1);
        end
        mode_selector_in = 1'b1;
        for (int i = 1; i <= 40; i++) begin
            step();
            check("release_mode", mode_selector_out, (i >= 19) ? 1'b1 : 1'b0);
        end

        glitch_watch = 1'b1;
        for (int g = 0; g < 5; g++) begin
            mode_selector_in  = 1'b0;
            light_selector_in = 1'b0;
            #100;
            mode_selector_in  = 1'b1;
            light_selector_in = 1'b1;
            #1000;
        end
        repeat (30) step();
        glitch_watch = 1'b0;
        check("glitch_never_changed", glitch_bad, 1'b0);
        check("glitch_mode_final", mode_selector_out, 1'b1);
        check("glitch_light_final", light_selector_out, 1'b1);

        for (int k = 0; k < 10; k++) begin
            mode_selector_in = (k % 2 == 0) ? 1'b0 : 1'b1;
            repeat (3) begin
                step();
                check("bounce_hold", mode_selector_out, 1'b1);
            end
        end
        mode_selector_in = 1'b0;
        for (int i = 1; i <= 30; i++) begin
            step();
            check("bounce_mode", mode_selector_out, (i >= 19) ? 1'b0 : 1'b1);
        end
        mode_selector_in = 1'b1;
        for (int i = 1; i <= 30; i++) begin
            step();
            check("bounce_release", mode_selector_out, (i >= 19) ? 1'b1 : 1'b0);
        end

        mode_selector_in  = 1'b0;
        light_selector_in = 1'b0;
        for (int i = 1; i <= 25; i++) begin
            step();
            check("both_mode", mode_selector_out, (i >= 19) ? 1'b0 : 1'b1);
            check("both_light", light_selector_out, (i >= 19) ? 1'b0 : 1'b1);
        end

        reset_system = 1'b1;
        step();
        check("midreset_mode_now", mode_selector_out, 1'b1);
        check("midreset_light_now", light_selector_out, 1'b1);
        check("midreset_resetn_now", resetn_cube, 1'b0);
        repeat (2) step();
        reset_system = 1'b0;
        for (int i = 1; i <= 40; i++) begin
            step();
            check("midreset_resetn", resetn_cube, (i >= 32) ? 1'b1 : 1'b0);
            check("midreset_mode", mode_selector_out, (i >= 33) ? 1'b0 : 1'b1);
            check("midreset_light", light_selector_out, (i >= 33) ? 1'b0 : 1'b1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
